int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that consumes level-sensitive interrupt lines from peripherals such as the timer (`int_sig_o`) and arbitrates them to the core. It latches pending sources, selects the highest-priority enabled one, and presents a registered request and ID to the core with a request/acknowledge handshake. The selected interrupt stays in service until software writes a completion. Register access uses the same 32-bit slave bus as the other peripherals (`addr_i` / `data_i` / `we_i` / `data_o`).

## Interface
- NUM_SRC, default 8: number of interrupt sources, legal range 1..31. Source i has ID i+1; ID 0 means none.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_i  in  NUM_SRC  level interrupt lines, synchronous to clk, bit i = source i
- data_i  in  32  bus write data
- addr_i  in  32  bus address; only [3:0] decoded
- we_i  in  1  bus write enable, 1 = write
- data_o  out  32  bus read data, combinational from addr_i[3:0]
- int_req_o  out  1  registered interrupt request to core
- int_id_o  out  5  registered ID of the requested / in-service interrupt
- int_ack_i  in  1  core accepts request; sampled only while int_req_o=1

## Operation
- Registers, decoded on addr_i[3:0]; other offsets read 0, writes ignored; unimplemented bits read 0:
  - 0x0 ENABLE, rw: per-source enable in bits [NUM_SRC-1:0].
  - 0x4 PENDING, ro: pending bits.
  - 0x8 CLAIM, rw: read returns in-service ID (0 if none). Write = complete.
  - 0xC CTRL, rw: bit0 = global enable.
- Pending update, each cycle for each source i:
  - Set when src_i[i]=1, ENABLE[i]=1, and i is not the in-service source.
  - Cleared when ENABLE[i]=0.
  - Cleared on ack of i.
  - Otherwise holds.
  - Sources that are high but disabled are ignored, not remembered.
- Priority: lowest index wins.
- FSM states IDLE, REQ, BUSY.
  - **IDLE**: if CTRL[0]=1 and PENDING≠0:
    - latch winner ID into cur_id;
    - go to REQ.
  - **REQ**: int_req_o=1, int_id_o=cur_id. cur_id is frozen; a higher-priority arrival does not preempt.
    - int_ack_i=1: clear pending[cur_id-1], mark it in service, go to BUSY.
    - Else, if CTRL[0]=0 or pending[cur_id-1]=0: go to IDLE (request withdrawn, other pending bits kept).
    - Ack wins over a simultaneous withdraw condition.
  - **BUSY**: int_req_o=0, int_id_o=cur_id, CLAIM reads cur_id.
    - A write to 0x8 with data_i[4:0]==cur_id: go to IDLE, in-service cleared.
    - A write with a non-matching ID is ignored.
    - CTRL[0]=0 does not abort BUSY.
- In IDLE, int_id_o=0 and CLAIM reads 0.
- A source still high after completion re-pends; this is level re-trigger.
- Reset mid-operation returns to IDLE and clears all state. ENABLE, PENDING, CTRL, cur_id, int_req_o and int_id_o all reset to 0.

## Timing
- src_i[i] rises before edge N → PENDING[i]=1 after N → state REQ and int_req_o=1 after N+1. Request latency is 2 cycles.
- int_ack_i=1 at edge M while in REQ → int_req_o=0 and PENDING[i]=0 after M.
- Complete write at edge K → IDLE after K. If the source is still high: pending after K+1, int_req_o=1 after K+2.
- A bus write and a pending update to the same cycle are independent. An ENABLE write takes effect on pending at the next edge.
- data_o has no read side effects.

## Test plan
- NUM_SRC=8; CTRL=1, ENABLE=0xFF; src_i=0x08 for 1 cycle → PENDING=0x08, int_req_o=1 with int_id_o=4 two cycles later; ack → int_req_o=0, PENDING=0, CLAIM reads 4.
- src_i=0x24 simultaneously → int_id_o=3 first; after ack and complete write of 3, int_id_o=6 requested; complete 6 → IDLE, CLAIM=0.
- In BUSY with ID 4, write CLAIM=5 → remains BUSY; write 4 → IDLE. With src_i[3] still held high, int_req_o=1, int_id_o=4 again 2 cycles after the complete.
- In REQ for ID 2, write CTRL=0 → int_req_o=0 next cycle, PENDING[1] kept; CTRL=1 → request re-issued. Repeat with ack asserted in the same cycle as CTRL=0 → BUSY.
- ENABLE=0x00, src_i=0xFF → PENDING=0, no request. Then set ENABLE=0x80 → int_id_o=8. Clear ENABLE in REQ → withdraw to IDLE.
- Assert rst_n=0 in BUSY → all outputs 0, CLAIM=0, ENABLE=0 immediately (asynchronous).

Source files
------------

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_if
// Brief    : Register bus and core request/ack bundle for int_ctrl.
// Revision : 1.0
// ============================================================================
interface int_ctrl_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_req_o;
  logic [4:0]  int_id_o;
  logic        int_ack_i;

  modport slave (
    input  addr_i, data_i, we_i, int_ack_i,
    output data_o, int_req_o, int_id_o
  );

  modport master (
    output addr_i, data_i, we_i, int_ack_i,
    input  data_o, int_req_o, int_id_o
  );
endinterface
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Brief    : Level-sensitive interrupt controller, fixed priority, claim/complete.
// Revision : 1.0
// ============================================================================
module int_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  int_ctrl_if.slave          bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               ctrl_q;
  logic [4:0]         cur_id_q, cur_id_d;
  logic [4:0]         id_q, id_d;
  logic               req_q, req_d;

  logic [4:0]         win_id;
  logic               cur_pend;
  logic [NUM_SRC-1:0] in_svc;
  logic [NUM_SRC-1:0] acked;
  logic               wr_enable, wr_claim, wr_ctrl;
  logic               unused_bits;

  assign wr_enable   = bus.we_i && (bus.addr_i[3:0] == 4'h0);
  assign wr_claim    = bus.we_i && (bus.addr_i[3:0] == 4'h8);
  assign wr_ctrl     = bus.we_i && (bus.addr_i[3:0] == 4'hC);
  assign unused_bits = ^{bus.addr_i[31:4], bus.data_i};

  // Descending scan so the lowest pending index is the last to assign win_id.
  always_comb begin
    win_id   = '0;
    cur_pend = 1'b0;
    in_svc   = '0;
    acked    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) win_id = 5'(i + 1);
      if (cur_id_q == 5'(i + 1)) begin
        cur_pend = pending_q[i];
        in_svc[i] = (state_q == BUSY);
        acked[i]  = (state_q == REQ) && bus.int_ack_i;
      end
    end
    // Ack clear dominates a still-high level on the same edge.
    pending_d = (pending_q | (src_i & enable_q & ~in_svc)) & enable_q & ~acked;
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      IDLE: begin
        if (ctrl_q && (|pending_q)) begin
          cur_id_d = win_id;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack_i)              state_d = BUSY;
        else if (!ctrl_q || !cur_pend)  state_d = IDLE;
      end
      BUSY: begin
        if (wr_claim && (bus.data_i[4:0] == cur_id_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
    id_d  = (state_d == IDLE) ? 5'd0 : cur_id_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      ctrl_q    <= 1'b0;
      cur_id_q  <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cur_id_q  <= cur_id_d;
      id_q      <= id_d;
      req_q     <= req_d;
      if (wr_enable) enable_q <= bus.data_i[NUM_SRC-1:0];
      if (wr_ctrl)   ctrl_q   <= bus.data_i[0];
    end
  end

  always_comb begin
    bus.data_o = '0;
    case (bus.addr_i[3:0])
      4'h0:    bus.data_o = 32'(enable_q);
      4'h4:    bus.data_o = 32'(pending_q);
      4'h8:    bus.data_o = (state_q == BUSY) ? 32'(cur_id_q) : 32'd0;
      4'hC:    bus.data_o = {31'd0, ctrl_q};
      default: bus.data_o = '0;
    endcase
  end

  assign bus.int_req_o = req_q;
  assign bus.int_id_o  = id_q;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Brief    : Scoreboard bench for int_ctrl: directed scenarios plus random rounds.
// Revision : 1.0
// ============================================================================
module tb_int_ctrl;
  localparam int NUM_SRC = 8;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] src_i = '0;

  int_ctrl_if bus ();

  int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src_i (src_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr_i = a;
    bus.data_i = d;
    bus.we_i   = 1'b1;
    tick();
    bus.we_i   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr_i = a;
    #1;
    check(name, bus.data_o, exp);
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!bus.int_req_o && n < max) begin
      tick();
      n++;
    end
    check("req_seen", 32'(bus.int_req_o), 32'd1);
  endtask

  // Accept the pending request for id and leave it in service.
  task automatic take(input int id, input int dly);
    wait_req(20);
    check("take_id", 32'(bus.int_id_o), 32'(id));
    repeat (dly) tick();
    bus.int_ack_i = 1'b1;
    tick();
    bus.int_ack_i = 1'b0;
    check("ack_req_low", 32'(bus.int_req_o), 32'd0);
    read_check("claim_busy", 32'h8, 32'(id));
    bus.addr_i = 32'h4;
    #1;
    check("ack_pend_clr", (bus.data_o >> (id - 1)) & 32'd1, 32'd0);
  endtask

  task automatic complete(input int id);
    bus_write(32'h8, 32'(id));
    read_check("claim_idle", 32'h8, 32'd0);
  endtask

  // Scoreboard monitor: every new request must match the oldest expected ID.
  always @(negedge clk) begin
    int e;
    if (rst_n && bus.int_req_o && !prev_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_req: got id %0d, expected no request", bus.int_id_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_req_id", 32'(bus.int_id_o), 32'(e));
      end
    end
    prev_req = bus.int_req_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] en, s, exp_pend;
    int         n;

    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus.we_i      = 1'b0;
    bus.int_ack_i = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req", 32'(bus.int_req_o), 32'd0);
    check("rst_id", 32'(bus.int_id_o), 32'd0);
    read_check("rst_enable", 32'h0, 32'd0);
    read_check("rst_pending", 32'h4, 32'd0);
    read_check("rst_claim", 32'h8, 32'd0);
    read_check("rst_ctrl", 32'hC, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single source, latency and ack
    bus_write(32'hC, 32'd1);
    bus_write(32'h0, 32'hFF);
    read_check("rd_ctrl", 32'hC, 32'd1);
    read_check("rd_unmapped", 32'h2, 32'd0);
    exp_q.push_back(4);
    src_i = 8'h08;
    tick();
    src_i = '0;
    read_check("t1_pending", 32'h4, 32'h08);
    check("t1_req_early", 32'(bus.int_req_o), 32'd0);
    tick();
    check("t1_req", 32'(bus.int_req_o), 32'd1);
    check("t1_id", 32'(bus.int_id_o), 32'd4);
    bus.int_ack_i = 1'b1;
    tick();
    bus.int_ack_i = 1'b0;
    check("t1_ack_req", 32'(bus.int_req_o), 32'd0);
    read_check("t1_ack_pend", 32'h4, 32'd0);
    read_check("t1_claim", 32'h8, 32'd4);
    complete(4);

    // Two simultaneous sources served in priority order
    exp_q.push_back(3);
    exp_q.push_back(6);
    src_i = 8'h24;
    tick();
    src_i = '0;
    take(3, 0);
    read_check("t2_pend", 32'h4, 32'h20);
    complete(3);
    take(6, 1);
    complete(6);
    check("t2_idle_req", 32'(bus.int_req_o), 32'd0);
    check("t2_idle_id", 32'(bus.int_id_o), 32'd0);

    // Wrong-ID complete ignored; level re-trigger after real complete
    exp_q.push_back(4);
    exp_q.push_back(4);
    src_i = 8'h08;
    take(4, 0);
    read_check("t3_busy_pend", 32'h4, 32'd0);
    bus_write(32'h8, 32'd5);
    read_check("t3_claim_kept", 32'h8, 32'd4);
    bus_write(32'h8, 32'd4);
    check("t3_k_req", 32'(bus.int_req_o), 32'd0);
    read_check("t3_k_pend", 32'h4, 32'd0);
    tick();
    read_check("t3_k1_pend", 32'h4, 32'h08);
    check("t3_k1_req", 32'(bus.int_req_o), 32'd0);
    tick();
    check("t3_k2_req", 32'(bus.int_req_o), 32'd1);
    check("t3_k2_id", 32'(bus.int_id_o), 32'd4);
    src_i = '0;
    take(4, 0);
    complete(4);

    // Global disable withdraws; ack in the same cycle wins
    exp_q.push_back(2);
    src_i = 8'h02;
    tick();
    src_i = '0;
    wait_req(20);
    bus_write(32'hC, 32'd0);
    tick();
    check("t4_withdraw", 32'(bus.int_req_o), 32'd0);
    read_check("t4_pend_kept", 32'h4, 32'h02);
    exp_q.push_back(2);
    bus_write(32'hC, 32'd1);
    wait_req(20);
    bus.int_ack_i = 1'b1;
    bus_write(32'hC, 32'd0);
    bus.int_ack_i = 1'b0;
    check("t4_ack_req", 32'(bus.int_req_o), 32'd0);
    read_check("t4_ack_claim", 32'h8, 32'd2);
    tick();
    read_check("t4_busy_hold", 32'h8, 32'd2);
    bus_write(32'hC, 32'd1);
    complete(2);

    // Disabled sources ignored; per-source disable withdraws
    bus_write(32'h0, 32'h00);
    src_i = 8'hFF;
    repeat (3) tick();
    read_check("t5_pend_none", 32'h4, 32'd0);
    check("t5_no_req", 32'(bus.int_req_o), 32'd0);
    exp_q.push_back(8);
    bus_write(32'h0, 32'h80);
    wait_req(20);
    check("t5_id", 32'(bus.int_id_o), 32'd8);
    bus_write(32'h0, 32'h00);
    n = 0;
    while (bus.int_req_o && n < 5) begin
      tick();
      n++;
    end
    check("t5_withdraw", 32'(bus.int_req_o), 32'd0);
    read_check("t5_pend_clr", 32'h4, 32'd0);
    src_i = '0;
    tick();

    // Random rounds: expected pending = pulse & enable, served lowest index first
    for (int r = 0; r < 40; r++) begin
      en = 8'($urandom_range(0, 255));
      s  = 8'($urandom_range(1, 255));
      bus_write(32'h0, 32'(en));
      exp_pend = s & en;
      for (int b = 0; b < NUM_SRC; b++)
        if (exp_pend[b]) exp_q.push_back(b + 1);
      src_i = s;
      tick();
      src_i = '0;
      read_check("rnd_pending", 32'h4, 32'(exp_pend));
      if (exp_pend == 8'd0) begin
        repeat (3) tick();
        check("rnd_no_req", 32'(bus.int_req_o), 32'd0);
      end else begin
        for (int b = 0; b < NUM_SRC; b++) begin
          if (exp_pend[b]) begin
            take(b + 1, int'($urandom_range(0, 3)));
            complete(b + 1);
          end
        end
      end
    end

    // Asynchronous reset while in service
    bus_write(32'h0, 32'hFF);
    exp_q.push_back(1);
    src_i = 8'h01;
    tick();
    src_i = '0;
    take(1, 0);
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.int_req_o), 32'd0);
    check("arst_id", 32'(bus.int_id_o), 32'd0);
    read_check("arst_claim", 32'h8, 32'd0);
    read_check("arst_enable", 32'h0, 32'd0);
    read_check("arst_pending", 32'h4, 32'd0);
    read_check("arst_ctrl", 32'hC, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
